dvi_tmds_encoder: RTL and testbench

//  Downstream stage of the top-level VGA output flops: consumes registered hsync/vsync/de/RGB565 at pixel rate.

---
 rtl/dvi_tmds_encoder_pkg.sv | 22 ++
 rtl/dvi_tmds_encoder_channel.sv | 74 +++++++
 rtl/dvi_tmds_encoder.sv | 76 +++++++
 tb/tb_dvi_tmds_encoder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_tmds_encoder_pkg.sv
// dvi_tmds_encoder_pkg: TMDS control/guard symbols, widths and the S1 pixel bundle shared by the encoder
package dvi_tmds_encoder_pkg;
    localparam int SYM_W = 10;
    localparam int CNT_W = 5;
    localparam logic [SYM_W-1:0] CTL_00 = 10'h354;
    localparam logic [SYM_W-1:0] CTL_01 = 10'h0AB;
    localparam logic [SYM_W-1:0] CTL_10 = 10'h154;
    localparam logic [SYM_W-1:0] CTL_11 = 10'h2AB;
    localparam logic [SYM_W-1:0] GUARD_CH0 = 10'h2CC;
    localparam logic [SYM_W-1:0] GUARD_CH1 = 10'h133;
    localparam logic [SYM_W-1:0] GUARD_CH2 = 10'h2CC;
    typedef struct packed {
        logic       de;
        logic [1:0] ctl;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } s1_t;
    function automatic logic [SYM_W-1:0] ctl_token(input logic [1:0] c);
        return c == 2'b00 ? CTL_00 : c == 2'b01 ? CTL_01 : c == 2'b10 ? CTL_10 : CTL_11;
    endfunction
endpackage

// File: rtl/dvi_tmds_encoder_channel.sv
// tmds_channel: one TMDS lane; S2 transition-minimises, S3 DC-balances against this lane's own disparity
module tmds_channel
    import dvi_tmds_encoder_pkg::*;
#(
    parameter logic [SYM_W-1:0] GUARD = GUARD_CH0
) (
    input  logic             pix_clk,
    input  logic             pix_rstn,
    input  logic             de,
    input  logic [1:0]       ctl,
    input  logic [7:0]       d,
    input  logic             guard_req,
    output logic [SYM_W-1:0] sym
);
    logic [3:0]              n1;
    logic                    use_xnor;
    logic [8:0]              qm_d;
    logic [8:0]              qm;
    logic [3:0]              n1q;
    logic                    de_q;
    logic [1:0]              ctl_q;
    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] cnt_d;
    logic signed [CNT_W-1:0] diff;
    logic [SYM_W-1:0]        sym_d;

    always_comb begin
        n1 = 4'($countones(d));
        use_xnor = n1 > 4'd4 || (n1 == 4'd4 && !d[0]);
        qm_d = {~use_xnor, 8'h00};
        qm_d[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ d[i]) : qm_d[i-1] ^ d[i];
    end

    always_ff @(posedge pix_clk or negedge pix_rstn)
        if (!pix_rstn) begin
            qm <= '0;
            n1q <= '0;
            de_q <= 1'b0;
            ctl_q <= 2'b00;
        end else begin
            qm <= qm_d;
            n1q <= 4'($countones(qm_d[7:0]));
            de_q <= de;
            ctl_q <= ctl;
        end

    // diff = ones - zeros of q_m[7:0], always even in -8..8
    always_comb begin
        diff = CNT_W'($signed({1'b0, n1q, 1'b0}) - 6'sd8);
        sym_d = {1'b0, qm[8], qm[7:0]};
        cnt_d = cnt + diff - (qm[8] ? 5'sd0 : 5'sd2);
        if (!de_q) begin
            sym_d = guard_req ? GUARD : ctl_token(ctl_q);
            cnt_d = '0;
        end else if (cnt == 5'sd0 || diff == 5'sd0) begin
            sym_d = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_d = qm[8] ? cnt + diff : cnt - diff;
        end else if ((cnt > 5'sd0 && diff > 5'sd0) || (cnt < 5'sd0 && diff < 5'sd0)) begin
            sym_d = {1'b1, qm[8], ~qm[7:0]};
            cnt_d = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
        end
    end

    always_ff @(posedge pix_clk or negedge pix_rstn)
        if (!pix_rstn) begin
            sym <= CTL_00;
            cnt <= '0;
        end else begin
            sym <= sym_d;
            cnt <= cnt_d;
        end
endmodule

// File: rtl/dvi_tmds_encoder.sv
// dvi_tmds_encoder: registered VGA RGB565 + syncs to three TMDS symbols per pix_clk, 3-stage pipeline.
// Define TMDS_VIDEO_GUARD_EN to replace the two blanking symbols before each de rise with the video guard band.
module dvi_tmds_encoder
    import dvi_tmds_encoder_pkg::*;
#(
    parameter bit HSYNC_INV = 1'b0,
    parameter bit VSYNC_INV = 1'b0
) (
    input  logic             pix_clk,
    input  logic             pix_rstn,
    input  logic             vga_hsync,
    input  logic             vga_vsync,
    input  logic             vga_de,
    input  logic [15:0]      vga_rgb,
    output logic [SYM_W-1:0] tmds_ch0,
    output logic [SYM_W-1:0] tmds_ch1,
    output logic [SYM_W-1:0] tmds_ch2
);
    s1_t  s1;
    logic guard_req;

    always_ff @(posedge pix_clk or negedge pix_rstn)
        if (!pix_rstn)
            s1 <= '0;
        else
            s1 <= '{de:  vga_de,
                    ctl: {vga_vsync ^ VSYNC_INV, vga_hsync ^ HSYNC_INV},
                    r:   {vga_rgb[15:11], vga_rgb[15:13]},
                    g:   {vga_rgb[10:5], vga_rgb[10:9]},
                    b:   {vga_rgb[4:0], vga_rgb[4:2]}};

`ifdef TMDS_VIDEO_GUARD_EN
    logic [1:0] live;

    always_ff @(posedge pix_clk or negedge pix_rstn)
        if (!pix_rstn)
            live <= 2'b00;
        else
            live <= {live[0], 1'b1};

    // S2 holds slot k, S1 holds k+1 and the input pins carry k+2; live[1] masks post-reset bubbles
    assign guard_req = live[1] & (s1.de | vga_de);
`else
    assign guard_req = 1'b0;
`endif

    tmds_channel #(.GUARD(GUARD_CH0)) u_ch0 (
        .pix_clk   (pix_clk),
        .pix_rstn  (pix_rstn),
        .de        (s1.de),
        .ctl       (s1.ctl),
        .d         (s1.b),
        .guard_req (guard_req),
        .sym       (tmds_ch0)
    );

    tmds_channel #(.GUARD(GUARD_CH1)) u_ch1 (
        .pix_clk   (pix_clk),
        .pix_rstn  (pix_rstn),
        .de        (s1.de),
        .ctl       (2'b00),
        .d         (s1.g),
        .guard_req (guard_req),
        .sym       (tmds_ch1)
    );

    tmds_channel #(.GUARD(GUARD_CH2)) u_ch2 (
        .pix_clk   (pix_clk),
        .pix_rstn  (pix_rstn),
        .de        (s1.de),
        .ctl       (2'b00),
        .d         (s1.r),
        .guard_req (guard_req),
        .sym       (tmds_ch2)
    );
endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// tb_dvi_tmds_encoder: randomized self-checking bench for dvi_tmds_encoder against a spec-level TMDS model
module tb_dvi_tmds_encoder;
`ifdef TMDS_VIDEO_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif
    localparam int GUARD_SYM [3] = '{'h2CC, 'h133, 'h2CC};
    localparam int TOK [4] = '{'h354, 'h0AB, 'h154, 'h2AB};

    logic        pix_clk = 1'b0;
    logic        pix_rstn = 1'b0;
    logic        vga_hsync = 1'b0;
    logic        vga_vsync = 1'b0;
    logic        vga_de = 1'b0;
    logic [15:0] vga_rgb = '0;
    logic [9:0]  tmds_ch0;
    logic [9:0]  tmds_ch1;
    logic [9:0]  tmds_ch2;
    logic [9:0]  ch [3];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          de_h[$];
    int          c_h[$];
    int          rgb_h[$];
    int          cnt [3];
    int          exp_s [3];
    int          dsum [3];

    always #5 pix_clk = ~pix_clk;

    assign ch[0] = tmds_ch0;
    assign ch[1] = tmds_ch1;
    assign ch[2] = tmds_ch2;

    dvi_tmds_encoder dut (
        .pix_clk   (pix_clk),
        .pix_rstn  (pix_rstn),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_de    (vga_de),
        .vga_rgb   (vga_rgb),
        .tmds_ch0  (tmds_ch0),
        .tmds_ch1  (tmds_ch1),
        .tmds_ch2  (tmds_ch2)
    );

    function automatic int ones(input int v, input int w);
        int s = 0;
        for (int i = 0; i < w; i++) s += (v >> i) & 1;
        return s;
    endfunction

    function automatic int expand(input int v, input int w);
        return ((v << (8 - w)) | (v >> (2 * w - 8))) & 255;
    endfunction

    // Direct transcription of the DVI encoding rules on plain integers
    function automatic int encode(input int d, input int de, input int c, input int gsym, input int guard, inout int rd);
        int n1, q8, qm, n1q, n0q, sym, b;
        if (de == 0) begin
            rd = 0;
            return guard != 0 ? gsym : TOK[c];
        end
        n1 = ones(d, 8);
        q8 = (n1 > 4 || (n1 == 4 && (d & 1) == 0)) ? 0 : 1;
        qm = d & 1;
        for (int i = 1; i < 8; i++) begin
            b = ((qm >> (i - 1)) ^ (d >> i)) & 1;
            qm = qm | ((q8 != 0 ? b : 1 - b) << i);
        end
        n1q = ones(qm, 8);
        n0q = 8 - n1q;
        if (rd == 0 || n1q == n0q) begin
            sym = (q8 != 0 ? 'h100 : 'h200) | (q8 != 0 ? qm : (~qm & 255));
            rd += q8 != 0 ? n1q - n0q : n0q - n1q;
        end else if ((rd > 0 && n1q > n0q) || (rd < 0 && n0q > n1q)) begin
            sym = 'h200 | (q8 << 8) | (~qm & 255);
            rd += 2 * q8 + n0q - n1q;
        end else begin
            sym = (q8 << 8) | qm;
            rd += -2 * (1 - q8) + n1q - n0q;
        end
        return sym;
    endfunction

    task automatic model_restart();
        de_h.delete();
        c_h.delete();
        rgb_h.delete();
        de_h.push_back(0);
        c_h.push_back(0);
        rgb_h.push_back(0);
        cnt = '{0, 0, 0};
        dsum = '{0, 0, 0};
    endtask

    // Drive one input cycle, advance one clock, update the model, return on the falling edge
    task automatic step(input bit hs, input bit vs, input bit de, input logic [15:0] rgb);
        int k, g;
        int px [3];
        vga_hsync = hs;
        vga_vsync = vs;
        vga_de = de;
        vga_rgb = rgb;
        @(posedge pix_clk);
        de_h.push_back(int'(de));
        c_h.push_back(int'({vs, hs}));
        rgb_h.push_back(int'(rgb));
        k = de_h.size() - 3;
        if (k < 1) begin
            exp_s = '{'h354, 'h354, 'h354};
        end else begin
            g = (GUARD_EN && de_h[k] == 0 && (de_h[k+1] != 0 || de_h[k+2] != 0)) ? 1 : 0;
            px[0] = expand(rgb_h[k] & 31, 5);
            px[1] = expand((rgb_h[k] >> 5) & 63, 6);
            px[2] = expand((rgb_h[k] >> 11) & 31, 5);
            for (int i = 0; i < 3; i++)
                exp_s[i] = encode(px[i], de_h[k], i == 0 ? c_h[k] : 0, GUARD_SYM[i], g, cnt[i]);
        end
        @(negedge pix_clk);
    endtask

    task automatic test_reset();
        pix_rstn = 1'b0;
        vga_de = 1'b0;
        vga_hsync = 1'b0;
        vga_vsync = 1'b0;
        vga_rgb = 16'($urandom);
        repeat (3) begin
            @(negedge pix_clk);
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ch[i] !== 10'h354) begin
                    n_bad++;
                    $display("FAIL reset_hold ch%0d: got %h want 354", i, ch[i]);
                end
            end
        end
        pix_rstn = 1'b1;
        model_restart();
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 1'b0, 16'($urandom));
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ch[i] !== 10'h354) begin
                    n_bad++;
                    $display("FAIL post_reset ch%0d cycle %0d: got %h want 354", i, c, ch[i]);
                end
            end
        end
    endtask

    task automatic test_sync();
        for (int c = 1; c < 4; c++) begin
            repeat (3) step(1'(c & 1), 1'(c >> 1), 1'b0, 16'($urandom));
            n_cmp++;
            if (tmds_ch0 !== 10'(TOK[c])) begin
                n_bad++;
                $display("FAIL sync_token c=%0d ch0: got %h want %h", c, tmds_ch0, 10'(TOK[c]));
            end
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (ch[i] !== 10'h354) begin
                    n_bad++;
                    $display("FAIL sync_token c=%0d ch%0d: got %h want 354", c, i, ch[i]);
                end
            end
        end
    endtask

    task automatic test_zero_pixels();
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ch[i] !== 10'h100) begin
                n_bad++;
                $display("FAIL zero_first ch%0d: got %h want 100", i, ch[i]);
            end
        end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ch[i] !== 10'h3FF) begin
                n_bad++;
                $display("FAIL zero_second ch%0d: got %h want 3ff", i, ch[i]);
            end
        end
    endtask

    task automatic test_ones_pixel();
        for (int r = 0; r < 2; r++) begin
            step(1'b0, 1'b0, 1'b1, 16'hFFFF);
            step(1'b0, 1'b0, 1'b0, 16'($urandom));
            step(1'b0, 1'b0, 1'b0, 16'($urandom));
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ch[i] !== 10'h200) begin
                    n_bad++;
                    $display("FAIL ones_pixel round %0d ch%0d: got %h want 200", r, i, ch[i]);
                end
            end
            step(1'b0, 1'b0, 1'b0, 16'($urandom));
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ch[i] !== 10'h354) begin
                    n_bad++;
                    $display("FAIL ones_blank round %0d ch%0d: got %h want 354", r, i, ch[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int  run = 0;
        int  k;
        bit  de = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (run == 0) begin
                de = !de;
                run = de ? int'($urandom_range(1, 24)) : int'($urandom_range(1, 5));
            end
            run--;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), de, 16'($urandom));
            k = de_h.size() - 3;
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ch[i] !== 10'(exp_s[i])) begin
                    n_bad++;
                    $display("FAIL random ch%0d cycle %0d: got %h want %h", i, c, ch[i], 10'(exp_s[i]));
                end
                if (k >= 1 && de_h[k] != 0) begin
                    dsum[i] += 2 * $countones(ch[i]) - 10;
                    n_cmp++;
                    if (dsum[i] > 8 || dsum[i] < -8) begin
                        n_bad++;
                        $display("FAIL disparity ch%0d cycle %0d: got %0d want within +-8", i, c, dsum[i]);
                    end
                end else begin
                    dsum[i] = 0;
                end
            end
        end
    endtask

    task automatic test_guard();
        int want;
        repeat (4) step(1'b0, 1'b1, 1'b0, 16'($urandom));
        for (int s = 0; s < 2; s++) begin
            step(1'b0, 1'b0, 1'b1, 16'($urandom));
            for (int i = 0; i < 3; i++) begin
                want = GUARD_EN ? GUARD_SYM[i] : (i == 0 ? 'h154 : 'h354);
                n_cmp++;
                if (ch[i] !== 10'(want)) begin
                    n_bad++;
                    $display("FAIL guard_pre%0d ch%0d: got %h want %h", s, i, ch[i], 10'(want));
                end
            end
        end
        step(1'b1, 1'b0, 1'b0, 16'($urandom));
        step(1'b0, 1'b0, 1'b1, 16'($urandom));
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ch[i] !== 10'(exp_s[i])) begin
                n_bad++;
                $display("FAIL guard_gap_before ch%0d: got %h want %h", i, ch[i], 10'(exp_s[i]));
            end
        end
        step(1'b0, 1'b0, 1'b1, 16'($urandom));
        for (int i = 0; i < 3; i++) begin
            want = GUARD_EN ? GUARD_SYM[i] : (i == 0 ? 'h0AB : 'h354);
            n_cmp++;
            if (ch[i] !== 10'(want)) begin
                n_bad++;
                $display("FAIL guard_gap1 ch%0d: got %h want %h", i, ch[i], 10'(want));
            end
        end
        step(1'b0, 1'b0, 1'b0, 16'($urandom));
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ch[i] !== 10'(exp_s[i])) begin
                n_bad++;
                $display("FAIL guard_gap_after ch%0d: got %h want %h", i, ch[i], 10'(exp_s[i]));
            end
        end
    endtask

    task automatic test_reset_midline();
        repeat (3) step(1'b0, 1'b0, 1'b1, 16'($urandom));
        #2 pix_rstn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ch[i] !== 10'h354) begin
                n_bad++;
                $display("FAIL async_reset ch%0d: got %h want 354", i, ch[i]);
            end
        end
        @(negedge pix_clk);
        pix_rstn = 1'b1;
        model_restart();
        for (int c = 0; c < 40; c++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'(c > 1 && (c % 7) < 4), 16'($urandom));
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ch[i] !== 10'(exp_s[i])) begin
                    n_bad++;
                    $display("FAIL after_midline_reset ch%0d cycle %0d: got %h want %h", i, c, ch[i], 10'(exp_s[i]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_zero_pixels();
        test_ones_pixel();
        test_guard();
        test_random();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
